// File: rtl/note_pkg.sv
// Shared types for the note glyph path: glyph codes, glyph geometry and
// the per-scanline sequencer state encoding.
package note_pkg;

  typedef enum logic [2:0] {
    BLANK        = 3'd0,
    QUARTER      = 3'd1,
    HALF         = 3'd2,
    WHOLE        = 3'd3,
    EIGHTH_REST  = 3'd4,
    QUARTER_REST = 3'd5,
    HALF_REST    = 3'd6,
    WHOLE_REST   = 3'd7
  } glyph_code_t;

  localparam int unsigned GLYPH_H     = 8;
  localparam int unsigned GLYPH_ROW_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    FETCH,
    WRITE,
    NEXT
  } seq_state_t;

endpackage

// File: rtl/note_row_match.sv
// Decides whether an 8-row glyph at slot_y covers scanline cur_y and which
// glyph row that scanline falls on.
module note_row_match
  import note_pkg::*;
#(
  parameter int unsigned Y_W = 10
) (
  input  logic [Y_W-1:0]         cur_y,
  input  logic [Y_W-1:0]         slot_y,
  input  logic                   slot_valid,
  input  logic [2:0]             slot_code,
  output logic                   hit,
  output logic [GLYPH_ROW_W-1:0] row
);

  logic [Y_W:0] diff;

  // The extra top bit is a borrow: set when cur_y < slot_y, so a glyph near
  // the bottom of the screen never matches a line near the top.
  always_comb begin
    diff = {1'b0, cur_y} - {1'b0, slot_y};
    hit  = slot_valid && (slot_code != BLANK) && !diff[Y_W]
           && (diff < (Y_W + 1)'(GLYPH_H));
    row  = diff[GLYPH_ROW_W-1:0];
  end

endmodule

// File: rtl/note_line_sequencer.sv
// Per-scanline walk of the note slot table: fetches the glyph ROM row of every
// note covering the line and emits it as an 8-pixel line buffer write.
module note_line_sequencer
  import note_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned SLOT_W    = 4,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              line_start,
  input  logic [Y_W-1:0]    line_y,
  output logic [SLOT_W-1:0] slot_idx,
  input  logic              slot_valid,
  input  logic [2:0]        slot_code,
  input  logic [X_W-1:0]    slot_x,
  input  logic [Y_W-1:0]    slot_y,
  output logic [5:0]        rom_addr,
  input  logic [7:0]        rom_data,
  output logic              lb_we,
  output logic [X_W-1:0]    lb_x,
  output logic [7:0]        lb_bits,
  output logic              busy,
  output logic              line_done,
  output logic              overrun
);

  localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(NUM_SLOTS - 1);

  seq_state_t            state_q, state_d;
  logic [Y_W-1:0]        cur_y_q, cur_y_d;
  logic [SLOT_W-1:0]     idx_q, idx_d;
  logic [5:0]            rom_addr_q, rom_addr_d;
  logic [X_W-1:0]        lb_x_q, lb_x_d;
  logic [7:0]            lb_bits_q, lb_bits_d;
  logic                  hit;
  logic [GLYPH_ROW_W-1:0] row;

  note_row_match #(
    .Y_W (Y_W)
  ) u_row_match (
    .cur_y      (cur_y_q),
    .slot_y     (slot_y),
    .slot_valid (slot_valid),
    .slot_code  (slot_code),
    .hit        (hit),
    .row        (row)
  );

  always_comb begin
    state_d    = state_q;
    cur_y_d    = cur_y_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    lb_x_d     = lb_x_q;
    lb_bits_d  = lb_bits_q;
    case (state_q)
      IDLE: begin
        if (line_start) begin
          cur_y_d = line_y;
          idx_d   = '0;
          state_d = READ;
        end
      end
      READ:  state_d = CHECK;
      CHECK: begin
        if (hit) begin
          rom_addr_d = {slot_code, row};
          lb_x_d     = slot_x;
          state_d    = FETCH;
        end else begin
          state_d = NEXT;
        end
      end
      FETCH: begin
        lb_bits_d = rom_data;
        state_d   = WRITE;
      end
      WRITE: state_d = NEXT;
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + SLOT_W'(1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cur_y_q    <= '0;
      idx_q      <= '0;
      rom_addr_q <= '0;
      lb_x_q     <= '0;
      lb_bits_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_y_q    <= cur_y_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      lb_x_q     <= lb_x_d;
      lb_bits_q  <= lb_bits_d;
    end
  end

  // Status strobes decode the current state, so reset clears them at once.
  always_comb begin
    slot_idx  = idx_q;
    rom_addr  = rom_addr_q;
    lb_x      = lb_x_q;
    lb_bits   = lb_bits_q;
    lb_we     = (state_q == WRITE);
    busy      = (state_q != IDLE);
    line_done = (state_q == NEXT) && (idx_q == LAST_IDX);
    overrun   = line_start && (state_q != IDLE);
  end

endmodule

// File: tb/tb_note_line_sequencer.sv
// Self-checking bench for note_line_sequencer with a registered slot table,
// a combinational glyph ROM and a slot-level reference model.
module tb_note_line_sequencer;
  localparam int NS = 16;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] line_y = '0;
  logic [3:0] slot_idx;
  logic       slot_valid;
  logic [2:0] slot_code;
  logic [9:0] slot_x, slot_y;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic       lb_we;
  logic [9:0] lb_x;
  logic [7:0] lb_bits;
  logic       busy, line_done, overrun;

  logic       t_valid [NS];
  logic [2:0] t_code  [NS];
  logic [9:0] t_x     [NS];
  logic [9:0] t_y     [NS];
  logic [7:0] rom     [64];

  int tests = 0;
  int fails = 0;

  note_line_sequencer #(
    .NUM_SLOTS (16),
    .SLOT_W    (4),
    .X_W       (10),
    .Y_W       (10)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .line_start (line_start),
    .line_y     (line_y),
    .slot_idx   (slot_idx),
    .slot_valid (slot_valid),
    .slot_code  (slot_code),
    .slot_x     (slot_x),
    .slot_y     (slot_y),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .lb_we      (lb_we),
    .lb_x       (lb_x),
    .lb_bits    (lb_bits),
    .busy       (busy),
    .line_done  (line_done),
    .overrun    (overrun)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    slot_valid <= t_valid[slot_idx];
    slot_code  <= t_code[slot_idx];
    slot_x     <= t_x[slot_idx];
    slot_y     <= t_y[slot_idx];
  end

  assign rom_data = rom[rom_addr];

  task automatic clear_table();
    for (int i = 0; i < NS; i++) begin
      t_valid[i] = 1'b0;
      t_code[i]  = 3'($urandom);
      t_x[i]     = 10'($urandom);
      t_y[i]     = 10'($urandom);
    end
  endtask

  // Runs one line; pulse_at>0 raises line_start in that cycle after accept,
  // pulse_done raises it in the line_done cycle.
  task automatic run_line(input string name, input logic [9:0] y,
                          input int pulse_at, input bit pulse_done);
    logic [23:0] exp_q[$];
    logic [23:0] got, e;
    int exp_lat = 0;
    int d, k;
    bit done = 0;
    int busy_err = 0;
    for (int i = 0; i < NS; i++) begin
      d = int'(y) - int'(t_y[i]);
      if (t_valid[i] && t_code[i] != 3'd0 && d >= 0 && d < 8) begin
        exp_q.push_back({t_x[i], t_code[i], 3'(d), rom[{t_code[i], 3'(d)}]});
        exp_lat += 5;
      end else begin
        exp_lat += 3;
      end
    end
    @(negedge Clk);
    line_y = y;
    line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
    k = 1;
    while (!done && k <= 200) begin
      if (k == pulse_at) begin
        line_start = 1'b1;
        #1;
        tests++;
        if (overrun !== 1'b1) begin
          fails++;
          $display("FAIL %s overrun_mid cycle %0d: got %b, expected 1", name, k, overrun);
        end
      end
      if (lb_we === 1'b1) begin
        tests++;
        got = {lb_x, rom_addr, lb_bits};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s unexpected_write cycle %0d: got x=%0d addr=%h bits=%h, expected none",
                   name, k, lb_x, rom_addr, lb_bits);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL %s write cycle %0d: got x=%0d addr=%h bits=%h, expected x=%0d addr=%h bits=%h",
                     name, k, got[23:14], got[13:8], got[7:0], e[23:14], e[13:8], e[7:0]);
          end
        end
      end
      if (busy !== 1'b1) busy_err++;
      if (line_done === 1'b1) begin
        done = 1;
        tests++;
        if (k != exp_lat) begin
          fails++;
          $display("FAIL %s line_done_latency: got %0d, expected %0d", name, k, exp_lat);
        end
        if (pulse_done) begin
          line_start = 1'b1;
          #1;
          tests++;
          if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL %s overrun_at_done: got %b, expected 1", name, overrun);
          end
        end
      end
      @(negedge Clk);
      line_start = 1'b0;
      k++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s timeout: got no line_done in 200 cycles, expected at %0d", name, exp_lat);
    end
    tests++;
    if (busy_err != 0) begin
      fails++;
      $display("FAIL %s busy_during_line: got %0d low cycles, expected 0", name, busy_err);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s missing_writes: got %0d outstanding, expected 0", name, exp_q.size());
    end
    tests++;
    if ({busy, line_done, lb_we} !== 3'b000) begin
      fails++;
      $display("FAIL %s after_done: got busy/done/we=%b, expected 000", name, {busy, line_done, lb_we});
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({slot_idx, rom_addr, lb_x, lb_bits, lb_we, busy, line_done, overrun} !== '0) begin
      fails++;
      $display("FAIL %s: got idx=%h addr=%h x=%h bits=%h we=%b busy=%b done=%b ovr=%b, expected all 0",
               name, slot_idx, rom_addr, lb_x, lb_bits, lb_we, busy, line_done, overrun);
    end
  endtask

  task automatic test_reset();
    int seen_done = 0;
    #2 Reset = 1'b1;
    #1 check_all_zero("reset_initial");
    @(negedge Clk);
    Reset = 1'b0;
    clear_table();
    t_valid[1] = 1'b1; t_code[1] = 3'd2; t_x[1] = 10'd40; t_y[1] = 10'd200;
    t_valid[0] = 1'b0;
    @(negedge Clk);
    line_y = 10'd203;
    line_start = 1'b1;
    // slot 3 CHECK: slot0 miss (3) + slot1 hit (5) + slot2 miss (3) + 2
    for (int k = 0; k < 13; k++) begin
      @(negedge Clk);
      line_start = 1'b0;
      if (line_done === 1'b1) seen_done++;
    end
    Reset = 1'b1;
    #1 check_all_zero("reset_mid_line");
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (line_done === 1'b1) seen_done++;
    end
    Reset = 1'b0;
    tests++;
    if (seen_done != 0) begin
      fails++;
      $display("FAIL reset_no_done: got %0d line_done pulses, expected 0", seen_done);
    end
    t_valid[0] = 1'b1; t_code[0] = 3'd6; t_x[0] = 10'd8; t_y[0] = 10'd199;
    run_line("after_reset", 10'd203, 0, 0);
  endtask

  task automatic test_single_hit();
    clear_table();
    t_valid[2] = 1'b1; t_code[2] = 3'd1; t_x[2] = 10'd100; t_y[2] = 10'd50;
    run_line("single_hit", 10'd53, 0, 0);
  endtask

  task automatic test_boundary();
    clear_table();
    t_valid[0] = 1'b1; t_code[0] = 3'd7; t_x[0] = 10'd300; t_y[0] = 10'd50;
    run_line("boundary_49", 10'd49, 0, 0);
    run_line("boundary_50", 10'd50, 0, 0);
    run_line("boundary_57", 10'd57, 0, 0);
    run_line("boundary_58", 10'd58, 0, 0);
  endtask

  task automatic test_wrap_blank();
    clear_table();
    t_valid[4] = 1'b1; t_code[4] = 3'd3; t_x[4] = 10'd12;  t_y[4] = 10'd1020;
    t_valid[9] = 1'b1; t_code[9] = 3'd0; t_x[9] = 10'd500; t_y[9] = 10'd2;
    run_line("wrap_blank", 10'd2, 0, 0);
  endtask

  task automatic test_all_hit();
    for (int i = 0; i < NS; i++) begin
      t_valid[i] = 1'b1; t_code[i] = 3'd5; t_x[i] = 10'(16 * i); t_y[i] = 10'd99;
    end
    run_line("all_hit", 10'd100, 0, 0);
  endtask

  task automatic randomize_table(input logic [9:0] y);
    for (int i = 0; i < NS; i++) begin
      t_valid[i] = ($urandom_range(0, 3) != 0);
      t_code[i]  = 3'($urandom);
      t_x[i]     = 10'($urandom);
      if ($urandom_range(0, 2) == 0) t_y[i] = 10'($urandom);
      else t_y[i] = 10'(int'(y) - int'($urandom_range(0, 9)));
    end
  endtask

  task automatic test_overrun();
    logic [9:0] y;
    y = 10'($urandom_range(20, 1000));
    randomize_table(y);
    run_line("overrun", y, 10, 1);
  endtask

  task automatic test_back_to_back();
    logic [9:0] y;
    for (int n = 0; n < 10; n++) begin
      y = 10'($urandom_range(0, 1023));
      randomize_table(y);
      run_line("random", y, 0, 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = 8'($urandom);
    rom[6'b001011] = 8'hFF;
    rom[6'b111000] = 8'h00;
    rom[6'b101001] = 8'h18;
    clear_table();
    test_reset();
    test_single_hit();
    test_boundary();
    test_wrap_blank();
    test_all_hit();
    test_overrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
